keccak_msg_loader: RTL

//  Receiving end of the keccak IP host streams (TS_PARMS / TS_DATA). Accepts one

---
 rtl/keccak_msg_loader.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/keccak_msg_loader.sv
// Receives one parameter word and a stream of 64-bit message elements, applies
// Keccak pad10*1 and emits rate-sized blocks one 64-bit lane at a time.
module keccak_msg_loader #(
  parameter logic [7:0]  PAD_BYTE = 8'h01,
  parameter int unsigned RATE256  = 17,
  parameter int unsigned RATE512  = 9
) (
  input  logic        Clk40,
  input  logic        reset_n,
  input  logic        soft_reset,
  input  logic        parms_valid,
  input  logic [63:0] parms_element,
  output logic        parms_ready,
  input  logic        data_valid,
  input  logic [63:0] data_element,
  output logic        data_ready,
  output logic        lane_valid,
  input  logic        lane_ready,
  output logic [63:0] lane_data,
  output logic [4:0]  lane_idx,
  output logic        lane_blk_last,
  output logic        lane_msg_last,
  output logic [4:0]  rate_lanes,
  output logic        bits_err
);

  localparam logic [4:0] R256 = 5'(RATE256);
  localparam logic [4:0] R512 = 5'(RATE512);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PAD} state_e;

  state_e      state_q, state_d;
  logic [31:0] rem_q, rem_d;
  logic [4:0]  rate_q, rate_d;
  logic [4:0]  nidx_q, nidx_d;
  logic        padded_q, padded_d;
  logic        lv_q, lv_d;
  logic [63:0] ld_q, ld_d;
  logic [4:0]  li_q, li_d;
  logic        lb_q, lb_d;
  logic        lm_q, lm_d;
  logic        err_q, err_d;

  logic        adv;
  logic        blk_end;
  logic [3:0]  r;
  logic [63:0] masked;

  assign adv     = !lv_q || lane_ready;
  assign blk_end = (nidx_q == rate_q - 5'd1);
  assign r       = (rem_q >= 32'd8) ? 4'd8 : rem_q[3:0];

  // Bytes past the message end are cleared and the pad byte goes at byte r.
  always_comb begin
    masked = data_element;
    for (int unsigned k = 0; k < 8; k++) begin
      if (4'(k) == r)      masked[8*k +: 8] = PAD_BYTE;
      else if (4'(k) > r)  masked[8*k +: 8] = 8'h00;
    end
  end

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    rate_d   = rate_q;
    nidx_d   = nidx_q;
    padded_d = padded_q;
    lv_d     = lv_q;
    ld_d     = ld_q;
    li_d     = li_q;
    lb_d     = lb_q;
    lm_d     = lm_q;
    err_d    = 1'b0;
    if (adv) lv_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (parms_valid) begin
          rem_d    = parms_element[31:0];
          nidx_d   = '0;
          padded_d = 1'b0;
          case (parms_element[63:32])
            32'd512: rate_d = R512;
            32'd256: rate_d = R256;
            default: begin
              rate_d = R256;
              err_d  = 1'b1;
            end
          endcase
          state_d = (parms_element[31:0] == 32'd0) ? S_PAD : S_LOAD;
        end
      end
      S_LOAD: begin
        if (adv && data_valid) begin
          lv_d   = 1'b1;
          li_d   = nidx_q;
          lb_d   = blk_end;
          lm_d   = 1'b0;
          ld_d   = masked;
          nidx_d = blk_end ? '0 : nidx_q + 5'd1;
          rem_d  = rem_q - {28'd0, r};
          if (r != 4'd8 && blk_end) begin
            ld_d[63:56] = ld_d[63:56] | 8'h80;
            lm_d        = 1'b1;
          end
          // A full last element defers the pad byte to the next lane.
          if (rem_q <= 32'd8) begin
            padded_d = (r != 4'd8);
            state_d  = (r != 4'd8 && blk_end) ? S_IDLE : S_PAD;
          end
        end
      end
      S_PAD: begin
        if (adv) begin
          lv_d     = 1'b1;
          li_d     = nidx_q;
          lb_d     = blk_end;
          lm_d     = blk_end;
          ld_d     = '0;
          padded_d = 1'b1;
          if (!padded_q) ld_d[7:0] = PAD_BYTE;
          if (blk_end) begin
            ld_d[63:56] = ld_d[63:56] | 8'h80;
            nidx_d      = '0;
            state_d     = S_IDLE;
          end else begin
            nidx_d = nidx_q + 5'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk40 or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      rem_q    <= '0;
      rate_q   <= R256;
      nidx_q   <= '0;
      padded_q <= 1'b0;
      lv_q     <= 1'b0;
      ld_q     <= '0;
      li_q     <= '0;
      lb_q     <= 1'b0;
      lm_q     <= 1'b0;
      err_q    <= 1'b0;
    end else if (soft_reset) begin
      state_q  <= S_IDLE;
      rem_q    <= '0;
      rate_q   <= R256;
      nidx_q   <= '0;
      padded_q <= 1'b0;
      lv_q     <= 1'b0;
      ld_q     <= '0;
      li_q     <= '0;
      lb_q     <= 1'b0;
      lm_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      rate_q   <= rate_d;
      nidx_q   <= nidx_d;
      padded_q <= padded_d;
      lv_q     <= lv_d;
      ld_q     <= ld_d;
      li_q     <= li_d;
      lb_q     <= lb_d;
      lm_q     <= lm_d;
      err_q    <= err_d;
    end
  end

  assign parms_ready   = (state_q == S_IDLE);
  assign data_ready    = (state_q == S_LOAD) && adv;
  assign lane_valid    = lv_q;
  assign lane_data     = ld_q;
  assign lane_idx      = li_q;
  assign lane_blk_last = lb_q;
  assign lane_msg_last = lm_q;
  assign rate_lanes    = rate_q;
  assign bits_err      = err_q;

endmodule
